// File: rtl/reg_file.sv
// reg_file: renaming register file with per-register busy/tag, ROB commit bypass and flush.
module reg_file #(
  parameter int ROB_SIZE_WIDTH = 5,
  parameter int REG_NUM_WIDTH = 5
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      rob_valid,
  input  logic [REG_NUM_WIDTH-1:0]  rob_rd,
  input  logic [31:0]               rob_value,
  input  logic [ROB_SIZE_WIDTH-1:0] rob_rob_id,
  input  logic                      need_flush_in,
  input  logic                      dec_valid,
  input  logic [REG_NUM_WIDTH-1:0]  dec_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] dec_rob_id,
  input  logic [REG_NUM_WIDTH-1:0]  dec_rs1,
  input  logic [REG_NUM_WIDTH-1:0]  dec_rs2,
  output logic [31:0]               rs1_value,
  output logic [31:0]               rs2_value,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic [ROB_SIZE_WIDTH-1:0] rs1_dependency,
  output logic [ROB_SIZE_WIDTH-1:0] rs2_dependency
);
  localparam int N = 1 << REG_NUM_WIDTH;
  logic [31:0]               value [N];
  logic                      busy  [N];
  logic [ROB_SIZE_WIDTH-1:0] tag   [N];
  logic                      commit, rename;
  assign commit = rob_valid && rob_rd != '0;
  assign rename = dec_valid && dec_rd != '0 && !need_flush_in;
  // Flush clears busy first; a later rename in the same block would win, but flush suppresses it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < N; i++) begin
        value[i] <= '0;
        busy[i]  <= 1'b0;
        tag[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (need_flush_in)
        for (int i = 0; i < N; i++) busy[i] <= 1'b0;
      if (commit) begin
        value[rob_rd] <= rob_value;
        if (!need_flush_in && busy[rob_rd] && tag[rob_rd] == rob_rob_id) busy[rob_rd] <= 1'b0;
      end
      if (rename) begin
        busy[dec_rd] <= 1'b1;
        tag[dec_rd]  <= dec_rob_id;
      end
    end
  end
  logic [REG_NUM_WIDTH-1:0]  rs  [2];
  logic [31:0]               val [2];
  logic                      bsy [2];
  logic [ROB_SIZE_WIDTH-1:0] dep [2];
  assign rs[0] = dec_rs1;
  assign rs[1] = dec_rs2;
  for (genvar g = 0; g < 2; g++) begin : g_rd
    logic nz, byp;
    assign nz  = rs[g] != '0;
    assign byp = rob_valid && nz && rob_rd == rs[g] && busy[rs[g]] && tag[rs[g]] == rob_rob_id;
    assign val[g] = !nz ? 32'h0 : byp ? rob_value : value[rs[g]];
    assign bsy[g] = nz && busy[rs[g]] && !byp;
    assign dep[g] = nz ? tag[rs[g]] : '0;
  end
  assign rs1_value      = val[0];
  assign rs2_value      = val[1];
  assign rs1_busy       = bsy[0];
  assign rs2_busy       = bsy[1];
  assign rs1_dependency = dep[0];
  assign rs2_dependency = dep[1];
endmodule
